// File: rtl/fetch_unit.sv
// Instruction fetch: one request in flight, a one-entry skid, branch squash.
// FETCH_PERF_CNT_EN adds a saturating fetch_count output.
module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        exec,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        stall,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] instr_n, instr_pc_n;
  logic        valid_n;
  logic        skid_valid, skid_valid_n;
  logic [15:0] skid_data, skid_data_n;
  logic [15:0] skid_pc, skid_pc_n;
  logic        req_n;
  logic [15:0] addr_n;
  logic        squash, squash_n;
  logic        br, ack_acc, ack_ok, load, hlt;

  // Next-state, datapath and request decisions; branch outranks everything.
  always_comb begin
    br           = branch_taken && (state != HALT);
    ack_acc      = imem_req && imem_ack;
    ack_ok       = ack_acc && !squash && !br;
    state_n      = state;
    pc_n         = pc;
    instr_n      = instr;
    instr_pc_n   = instr_pc;
    valid_n      = instr_valid;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_pc_n    = skid_pc;
    req_n        = 1'b0;
    addr_n       = imem_addr;
    squash_n     = 1'b0;
    load         = 1'b0;

    if (ack_ok)
      pc_n = pc + 16'd1;

    if (br) begin
      pc_n         = branch_target;
      instr_n      = 16'h0000;
      valid_n      = 1'b0;
      skid_valid_n = 1'b0;
    end else if (skid_valid && !stall) begin
      instr_n      = skid_data;
      instr_pc_n   = skid_pc;
      valid_n      = 1'b1;
      skid_valid_n = 1'b0;
      load         = 1'b1;
    end else if (ack_ok && (!instr_valid || !stall)) begin
      instr_n    = imem_rdata;
      instr_pc_n = imem_addr;
      valid_n    = 1'b1;
      load       = 1'b1;
    end else if (ack_ok) begin
      skid_valid_n = 1'b1;
      skid_data_n  = imem_rdata;
      skid_pc_n    = imem_addr;
    end else if (instr_valid && !stall) begin
      instr_n = 16'h0000;
      valid_n = 1'b0;
    end

    hlt = load && (instr_n[15:14] == 2'b11) && (instr_n[7:4] == 4'hF);

    unique case (state)
      IDLE:    if (exec) state_n = FETCH;
      FETCH:   if (hlt)  state_n = HALT;
      HALT:    if (exec) state_n = FETCH;
      default: state_n = IDLE;
    endcase

    // A pending request holds address; a branch marks its data for discard.
    if (imem_req && !imem_ack) begin
      req_n    = 1'b1;
      addr_n   = imem_addr;
      squash_n = squash || br;
    end else if (state_n == FETCH && !skid_valid_n &&
                 (!valid_n || !stall)) begin
      req_n  = 1'b1;
      addr_n = pc_n;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= 16'h0000;
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
      instr_valid <= 1'b0;
      skid_valid  <= 1'b0;
      skid_data   <= 16'h0000;
      skid_pc     <= 16'h0000;
      imem_req    <= 1'b0;
      imem_addr   <= 16'h0000;
      squash      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= valid_n;
      skid_valid  <= skid_valid_n;
      skid_data   <= skid_data_n;
      skid_pc     <= skid_pc_n;
      imem_req    <= req_n;
      imem_addr   <= addr_n;
      squash      <= squash_n;
    end
  end

  assign halted = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
  // Count instructions entering instr, saturating at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      fetch_count <= 16'h0000;
    else if (load && fetch_count != 16'hFFFF)
      fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, skid, branch squash,
// HLT, PC wrap and reset while a request is pending.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        exec;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        stall;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .exec         (exec),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {15'd0, imem_req}, 16'h0000);
    chk({tag, "_addr"}, imem_addr, 16'h0000);
    chk({tag, "_instr"}, instr, 16'h0000);
    chk({tag, "_ipc"}, instr_pc, 16'h0000);
    chk({tag, "_valid"}, {15'd0, instr_valid}, 16'h0000);
    chk({tag, "_halted"}, {15'd0, halted}, 16'h0000);
  endtask

  initial begin
    reset = 1'b1;
    exec = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    stall = 1'b0;
    #2;
    chk_reset("rst");
    tick();
    tick();
    reset = 1'b0;

    // Streaming at one instruction per cycle
    exec = 1'b1;
    tick();
    exec = 1'b0;
    chk("start_req", {15'd0, imem_req}, 16'h0001);
    chk("start_addr", imem_addr, 16'h0000);
    imem_ack = 1'b1;
    imem_rdata = 16'h8001;
    tick();
    chk("s1_instr", instr, 16'h8001);
    chk("s1_ipc", instr_pc, 16'h0000);
    chk("s1_valid", {15'd0, instr_valid}, 16'h0001);
    chk("s1_addr", imem_addr, 16'h0001);
    imem_rdata = 16'h8002;
    tick();
    chk("s2_instr", instr, 16'h8002);
    chk("s2_ipc", instr_pc, 16'h0001);
    chk("s2_addr", imem_addr, 16'h0002);

    // Stall three cycles; ack arrives mid-stall into the skid
    imem_ack = 1'b0;
    stall = 1'b1;
    tick();
    chk("st1_instr", instr, 16'h8002);
    chk("st1_req", {15'd0, imem_req}, 16'h0001);
    chk("st1_addr", imem_addr, 16'h0002);
    imem_ack = 1'b1;
    imem_rdata = 16'h1234;
    tick();
    chk("st2_instr", instr, 16'h8002);
    chk("st2_valid", {15'd0, instr_valid}, 16'h0001);
    chk("st2_req", {15'd0, imem_req}, 16'h0000);
    imem_ack = 1'b0;
    tick();
    chk("st3_instr", instr, 16'h8002);
    stall = 1'b0;
    tick();
    chk("sk_instr", instr, 16'h1234);
    chk("sk_ipc", instr_pc, 16'h0002);
    chk("sk_req", {15'd0, imem_req}, 16'h0001);
    chk("sk_addr", imem_addr, 16'h0003);
    tick();
    chk("drain_valid", {15'd0, instr_valid}, 16'h0000);
    chk("drain_instr", instr, 16'h0000);
    chk("drain_addr", imem_addr, 16'h0003);

    // Walk to address 5, then branch while it is pending
    imem_ack = 1'b1;
    imem_rdata = 16'h0011;
    tick();
    chk("a3_ipc", instr_pc, 16'h0003);
    imem_rdata = 16'h0022;
    tick();
    chk("a4_ipc", instr_pc, 16'h0004);
    chk("a5_addr", imem_addr, 16'h0005);
    imem_ack = 1'b0;
    tick();
    branch_taken = 1'b1;
    branch_target = 16'h0040;
    tick();
    branch_taken = 1'b0;
    chk("br_hold_req", {15'd0, imem_req}, 16'h0001);
    chk("br_hold_addr", imem_addr, 16'h0005);
    chk("br_valid", {15'd0, instr_valid}, 16'h0000);
    imem_ack = 1'b1;
    imem_rdata = 16'hBEEF;
    tick();
    chk("sq_valid", {15'd0, instr_valid}, 16'h0000);
    chk("sq_instr", instr, 16'h0000);
    chk("sq_addr", imem_addr, 16'h0040);
    imem_rdata = 16'h0123;
    tick();
    chk("tgt_instr", instr, 16'h0123);
    chk("tgt_ipc", instr_pc, 16'h0040);

    // Branch beats stall and a same-cycle ack
    branch_taken = 1'b1;
    branch_target = 16'h0100;
    imem_rdata = 16'h0456;
    stall = 1'b1;
    tick();
    branch_taken = 1'b0;
    stall = 1'b0;
    chk("pri_valid", {15'd0, instr_valid}, 16'h0000);
    chk("pri_instr", instr, 16'h0000);
    chk("pri_addr", imem_addr, 16'h0100);

    // HLT fetch, ignored branch, resume on exec
    imem_rdata = 16'hC0F0;
    tick();
    chk("hlt_instr", instr, 16'hC0F0);
    chk("hlt_valid", {15'd0, instr_valid}, 16'h0001);
    chk("hlt_halted", {15'd0, halted}, 16'h0001);
    chk("hlt_req", {15'd0, imem_req}, 16'h0000);
    imem_ack = 1'b0;
    branch_taken = 1'b1;
    branch_target = 16'h0200;
    tick();
    branch_taken = 1'b0;
    chk("hlt2_halted", {15'd0, halted}, 16'h0001);
    chk("hlt2_req", {15'd0, imem_req}, 16'h0000);
    exec = 1'b1;
    tick();
    exec = 1'b0;
    chk("res_halted", {15'd0, halted}, 16'h0000);
    chk("res_req", {15'd0, imem_req}, 16'h0001);
    chk("res_addr", imem_addr, 16'h0101);

    // PC wrap at 0xFFFF
    branch_taken = 1'b1;
    branch_target = 16'hFFFF;
    imem_ack = 1'b1;
    tick();
    branch_taken = 1'b0;
    chk("wr_addr", imem_addr, 16'hFFFF);
    imem_rdata = 16'h0777;
    tick();
    chk("wr_ipc", instr_pc, 16'hFFFF);
    chk("wr_next", imem_addr, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    chk("cnt", fetch_count, 16'd8);
`endif

    // Reset while a request is pending; late ack must be ignored
    imem_ack = 1'b0;
    tick();
    chk("pend_req", {15'd0, imem_req}, 16'h0001);
    reset = 1'b1;
    #1;
    chk_reset("mid");
`ifdef FETCH_PERF_CNT_EN
    chk("cnt_rst", fetch_count, 16'd0);
`endif
    tick();
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'h0999;
    tick();
    chk("late_valid", {15'd0, instr_valid}, 16'h0000);
    chk("late_req", {15'd0, imem_req}, 16'h0000);
    imem_ack = 1'b0;
    exec = 1'b1;
    tick();
    exec = 1'b0;
    chk("late_addr", imem_addr, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports: exec  in  1  start pulse; begins fetching from current PC.
REQ-004 SHALL have ports: imem_req  out  1, imem_addr  out  16, imem_ack  in  1, imem_rdata  in  16  (instruction memory handshake).
REQ-005 SHALL have ports: branch_taken  in  1, branch_target  in  16  (PCSrc redirect from decode).
REQ-006 SHALL have ports: stall  in  1  downstream cannot accept a new instruction.
REQ-007 SHALL have ports: instr  out  16, instr_pc  out  16, instr_valid  out  1, halted  out  1.

Function
REQ-008 SHALL implement states IDLE, FETCH, HALT; reset enters IDLE.
REQ-009 SHALL move IDLE->FETCH or HALT->FETCH on exec=1; exec in FETCH ignored.
REQ-010 SHALL assert imem_req with imem_addr=pc in FETCH when no request outstanding, skid empty, and (instr_valid=0 or stall=0).
REQ-011 SHALL hold imem_req=1 and imem_addr stable until an edge with imem_ack=1; ack in the same cycle as first req assertion is legal (1-cycle minimum latency).
REQ-012 SHALL ignore imem_ack while imem_req=0.
REQ-013 SHALL, on accepted ack, set pc<=pc+1 (16-bit wrap, 0xFFFF->0x0000).
REQ-014 SHALL load instr<=imem_rdata, instr_pc<=request address, instr_valid<=1 on the ack edge when instr_valid=0 or stall=0.
REQ-015 SHALL capture ack data into a one-entry skid register when instr_valid=1 and stall=1; skid data moves to instr on first edge with stall=0.
REQ-016 SHALL, with instr_valid=1, stall=0 and no new data, clear instr_valid and set instr<=0x0000.
REQ-017 SHALL hold instr, instr_pc, instr_valid unchanged while stall=1.
REQ-018 SHALL, on branch_taken=1 (not in HALT), set pc<=branch_target, clear instr_valid, set instr<=0x0000, flush skid, and discard data of any outstanding request on its ack (no pc increment for it).
REQ-019 SHALL give branch_taken priority over stall and over a simultaneous ack.
REQ-020 SHALL detect HLT (instr[15:14]==2'b11 and instr[7:4]==4'b1111) when loaded into instr: present it valid, enter HALT on that edge, issue no further requests.
REQ-021 SHALL assert halted=1 exactly while in HALT; branch_taken ignored in HALT.
REQ-022 SHALL let an outstanding request complete normally if exec is asserted mid-fetch.

Reset
REQ-023 SHALL on reset force: pc=0x0000, state=IDLE, imem_req=0, imem_addr=0x0000, instr=0x0000, instr_pc=0x0000, instr_valid=0, halted=0, skid empty.
REQ-024 SHALL abandon any outstanding request on reset; a later ack with imem_req=0 is ignored.

Configuration
REQ-025 SHALL, with macro FETCH_PERF_CNT_EN defined, add output fetch_count (16 bits, reset 0x0000) incrementing once per instruction loaded into instr (skid and squashed data excluded), saturating at 0xFFFF.
REQ-026 SHALL, without FETCH_PERF_CNT_EN, omit the fetch_count port and counter; all other behaviour identical.

Verification
REQ-027 Reset, exec pulse, memory acks same cycle with rdata 0x8001,0x8002 -> instr 0x8001 pc 0x0000 then 0x8002 pc 0x0001, one per cycle.
REQ-028 stall=1 for 3 cycles while ack delivers 0x1234 -> instr holds prior value, 0x1234 appears first cycle after stall drops, none lost or duplicated.
REQ-029 branch_taken with target 0x0040 while request to 0x0005 outstanding -> its data discarded, next imem_addr=0x0040, instr_valid low one cycle.
REQ-030 Fetch 0xC0F0 (HLT) -> presented valid, halted=1, imem_req stays 0; exec -> fetch resumes at HLT address+1.
REQ-031 pc=0xFFFF fetched -> next imem_addr=0x0000; reset mid-request -> all outputs reset values, late ack ignored.
REQ-032 With FETCH_PERF_CNT_EN, 5 delivered plus 1 squashed fetch -> fetch_count=5.
